// File: rtl/lsq_pkg.sv
// Shared types for the load/store queue: per-entry lifecycle state, the entry
// record, and the word-granular address compare used by store-to-load forwarding.
package lsq_pkg;

  localparam int unsigned LSQ_XLEN = 32;

  typedef enum logic [2:0] {
    EMPTY,
    WAIT_ADDR,
    ADDR_OK,
    ISSUED,
    DONE
  } entry_state_e;

  typedef struct packed {
    logic                valid;
    logic                is_store;
    logic [LSQ_XLEN-1:0] pc;
    logic [LSQ_XLEN-1:0] addr;
    logic [LSQ_XLEN-1:0] data;
    entry_state_e        state;
  } lsq_entry_t;

  // Two addresses hit the same word when they differ only in the byte offset.
  function automatic logic word_match(input logic [LSQ_XLEN-1:0] a,
                                      input logic [LSQ_XLEN-1:0] b);
    return ((a ^ b) >> 2) == '0;
  endfunction

endpackage

// File: rtl/load_store_queue_if.sv
// Bundle of dispatch, execute, memory, completion and retire signals between
// the core (master) and the load/store queue (slave).
interface load_store_queue_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 4
);
  logic             dis_valid;
  logic             dis_is_store;
  logic [XLEN-1:0]  dis_pc;
  logic             dis_ready;
  logic [IDX_W-1:0] dis_idx;
  logic             exe_valid;
  logic [IDX_W-1:0] exe_idx;
  logic [XLEN-1:0]  exe_addr;
  logic [XLEN-1:0]  exe_data;
  logic             mem_rd_en;
  logic [XLEN-1:0]  mem_rd_addr;
  logic [XLEN-1:0]  mem_rd_data;
  logic             mem_wr_en;
  logic [XLEN-1:0]  mem_wr_addr;
  logic [XLEN-1:0]  mem_wr_data;
  logic             ld_done;
  logic [IDX_W-1:0] ld_done_idx;
  logic [XLEN-1:0]  ld_done_pc;
  logic [XLEN-1:0]  ld_done_data;
  logic             ld_done_fwd;
  logic             head_done;
  logic             ret_valid;
  logic             flush;

  modport master (
    output dis_valid, dis_is_store, dis_pc, exe_valid, exe_idx, exe_addr, exe_data,
           mem_rd_data, ret_valid, flush,
    input  dis_ready, dis_idx, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
           ld_done, ld_done_idx, ld_done_pc, ld_done_data, ld_done_fwd, head_done
  );

  modport slave (
    input  dis_valid, dis_is_store, dis_pc, exe_valid, exe_idx, exe_addr, exe_data,
           mem_rd_data, ret_valid, flush,
    output dis_ready, dis_idx, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
           ld_done, ld_done_idx, ld_done_pc, ld_done_data, ld_done_fwd, head_done
  );
endinterface

// File: rtl/lsq_age_select.sv
// Age-ordered selection over the circular queue. Entries are walked from head
// (oldest) to youngest; picks the oldest resolved load not blocked by an older
// unresolved store, and the youngest store older than that load that matches.
module lsq_age_select
  import lsq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  entry_state_e     state [DEPTH],
  input  logic [DEPTH-1:0] is_store,
  input  logic [IDX_W-1:0] head,
  input  logic [DEPTH-1:0] match,
  output logic             ld_found,
  output logic [IDX_W-1:0] ld_idx,
  output logic             st_found,
  output logic [IDX_W-1:0] st_idx
);

  // Oldest ADDR_OK load with no older store still waiting for its address.
  always_comb begin
    logic             blocked;
    logic [IDX_W-1:0] idx;
    ld_found = 1'b0;
    ld_idx   = '0;
    blocked  = 1'b0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + IDX_W'(k);
      if (!ld_found && !blocked && !is_store[idx] && state[idx] == ADDR_OK) begin
        ld_found = 1'b1;
        ld_idx   = idx;
      end
      if (is_store[idx] && state[idx] == WAIT_ADDR) blocked = 1'b1;
    end
  end

  // Youngest matching store strictly older than the selected load.
  always_comb begin
    logic             past_ld;
    logic [IDX_W-1:0] idx;
    st_found = 1'b0;
    st_idx   = '0;
    past_ld  = 1'b0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + IDX_W'(k);
      if (ld_found && idx == ld_idx) past_ld = 1'b1;
      if (ld_found && !past_ld && match[idx] && is_store[idx]) begin
        st_found = 1'b1;
        st_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/load_store_queue.sv
// Circular load/store queue. Entries are allocated in program order, resolved
// by the address FU, loads are forwarded from older stores or read from memory,
// and stores write memory only when retired from the head.
module load_store_queue
  import lsq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = LSQ_XLEN
) (
  input logic               clk,
  input logic               rstn,
  load_store_queue_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  lsq_entry_t       entries [DEPTH];
  logic [PTR_W-1:0] head, tail, count;
  logic [IDX_W-1:0] head_idx, tail_idx;

  logic             rd_inflight_p1;
  logic [IDX_W-1:0] rd_idx_p1;
  logic             fwd_done_p1;
  logic [IDX_W-1:0] fwd_idx_p1;
  logic [XLEN-1:0]  fwd_pc_p1, fwd_data_p1;

  entry_state_e     state_vec [DEPTH];
  logic [DEPTH-1:0] store_vec, match_vec;
  logic             ld_found, st_found;
  logic [IDX_W-1:0] ld_idx, st_idx;

  logic clear, dis_fire, ret_fire, sel_fire, fwd_fire, issue_fire, wr_fire, head_done_c;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];

  // Flush and reset share one path; flush overrides every other input.
  assign clear       = !rstn || bus.flush;
  assign head_done_c = (head != tail) && entries[head_idx].state == DONE;
  assign dis_fire    = bus.dis_valid && bus.dis_ready && !clear;
  assign ret_fire    = bus.ret_valid && head_done_c && !clear;
  assign sel_fire    = ld_found && !rd_inflight_p1 && !clear;
  assign fwd_fire    = sel_fire && st_found;
  assign issue_fire  = sel_fire && !st_found;
  assign wr_fire     = ret_fire && entries[head_idx].is_store;

  // Flatten entry fields for the selector and build the forwarding match mask.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_vec[i] = entries[i].state;
      store_vec[i] = entries[i].is_store;
      match_vec[i] = entries[i].valid && entries[i].is_store && entries[i].state == DONE &&
                     word_match(entries[i].addr, entries[ld_idx].addr);
    end
  end

  lsq_age_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_age_select (
    .state    (state_vec),
    .is_store (store_vec),
    .head     (head_idx),
    .match    (match_vec),
    .ld_found (ld_found),
    .ld_idx   (ld_idx),
    .st_found (st_found),
    .st_idx   (st_idx)
  );

  assign bus.dis_ready   = (count != PTR_W'(DEPTH));
  assign bus.dis_idx     = tail_idx;
  assign bus.head_done   = head_done_c;
  assign bus.mem_rd_en   = issue_fire;
  assign bus.mem_rd_addr = issue_fire ? entries[ld_idx].addr : '0;
  assign bus.mem_wr_en   = wr_fire;
  assign bus.mem_wr_addr = wr_fire ? entries[head_idx].addr : '0;
  assign bus.mem_wr_data = wr_fire ? entries[head_idx].data : '0;

  // A forwarded result and a memory return can never coincide: selection is
  // stalled while a read is in flight.
  always_comb begin
    bus.ld_done      = (fwd_done_p1 || rd_inflight_p1) && !clear;
    bus.ld_done_fwd  = fwd_done_p1 && !clear;
    bus.ld_done_idx  = '0;
    bus.ld_done_pc   = '0;
    bus.ld_done_data = '0;
    if (bus.ld_done) begin
      if (rd_inflight_p1) begin
        bus.ld_done_idx  = rd_idx_p1;
        bus.ld_done_pc   = entries[rd_idx_p1].pc;
        bus.ld_done_data = bus.mem_rd_data;
      end else begin
        bus.ld_done_idx  = fwd_idx_p1;
        bus.ld_done_pc   = fwd_pc_p1;
        bus.ld_done_data = fwd_data_p1;
      end
    end
  end

  // Per-entry lifecycle; each event targets an entry in a distinct state, so
  // they never collide on the same entry in one cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].state <= EMPTY;
      end
    end else begin
      if (dis_fire) begin
        entries[tail_idx].valid    <= 1'b1;
        entries[tail_idx].is_store <= bus.dis_is_store;
        entries[tail_idx].pc       <= bus.dis_pc;
        entries[tail_idx].state    <= WAIT_ADDR;
      end
      if (bus.exe_valid && entries[bus.exe_idx].state == WAIT_ADDR) begin
        entries[bus.exe_idx].addr  <= bus.exe_addr;
        entries[bus.exe_idx].data  <= bus.exe_data;
        // Stores have nothing left to do once resolved.
        entries[bus.exe_idx].state <= entries[bus.exe_idx].is_store ? DONE : ADDR_OK;
      end
      if (fwd_fire)       entries[ld_idx].state    <= DONE;
      if (issue_fire)     entries[ld_idx].state    <= ISSUED;
      if (rd_inflight_p1) entries[rd_idx_p1].state <= DONE;
      if (ret_fire) begin
        entries[head_idx].valid <= 1'b0;
        entries[head_idx].state <= EMPTY;
      end
    end
  end

  // Queue pointers, occupancy and the single-cycle completion flags.
  always_ff @(posedge clk) begin
    if (clear) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      rd_inflight_p1 <= 1'b0;
      fwd_done_p1    <= 1'b0;
    end else begin
      if (dis_fire) tail <= tail + PTR_W'(1);
      if (ret_fire) head <= head + PTR_W'(1);
      count          <= count + PTR_W'(dis_fire) - PTR_W'(ret_fire);
      rd_inflight_p1 <= issue_fire;
      fwd_done_p1    <= fwd_fire;
    end
  end

  // Completion payload captured alongside the control flags above.
  always_ff @(posedge clk) begin
    if (issue_fire) rd_idx_p1 <= ld_idx;
    if (fwd_fire) begin
      fwd_idx_p1  <= ld_idx;
      fwd_pc_p1   <= entries[ld_idx].pc;
      fwd_data_p1 <= entries[st_idx].data;
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: forwarding, memory loads, store ordering
// hazards, full/wrap behaviour and flush against an in-flight read.
module tb_load_store_queue;

  localparam int DEPTH = 16;
  localparam int XLEN  = 32;
  localparam int IDX_W = 4;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] mem_val = 32'h0;
  int          n_assert  = 0;
  int          n_fail    = 0;
  int          rd_pulses = 0;

  load_store_queue_if #(.XLEN(XLEN), .IDX_W(IDX_W)) bus ();

  load_store_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory returns read data exactly one cycle after the request.
  always @(posedge clk) bus.mem_rd_data <= bus.mem_rd_en ? mem_val : 32'h0;

  // Count read requests over the whole run.
  always @(negedge clk) if (bus.mem_rd_en) rd_pulses <= rd_pulses + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.dis_valid = 1'b0;
    bus.exe_valid = 1'b0;
    bus.ret_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic dispatch(input logic st, input logic [31:0] pc);
    bus.dis_valid    = 1'b1;
    bus.dis_is_store = st;
    bus.dis_pc       = pc;
  endtask

  task automatic exe(input logic [3:0] idx, input logic [31:0] addr, input logic [31:0] data);
    bus.exe_valid = 1'b1;
    bus.exe_idx   = idx;
    bus.exe_addr  = addr;
    bus.exe_data  = data;
  endtask

  function automatic logic [3:0] slot(input int seq);
    return 4'((8 + seq) % DEPTH);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dis_valid = 0; bus.dis_is_store = 0; bus.dis_pc = 0;
    bus.exe_valid = 0; bus.exe_idx = 0; bus.exe_addr = 0; bus.exe_data = 0;
    bus.ret_valid = 0; bus.flush = 0;

    // Reset
    tick(); tick();
    rstn = 1'b1;
    #1;
    check("rst_dis_ready", bus.dis_ready, 1);
    check("rst_dis_idx", bus.dis_idx, 0);
    check("rst_head_done", bus.head_done, 0);
    check("rst_mem_rd_en", bus.mem_rd_en, 0);
    check("rst_mem_rd_addr", bus.mem_rd_addr, 0);
    check("rst_mem_wr_en", bus.mem_wr_en, 0);
    check("rst_mem_wr_data", bus.mem_wr_data, 0);
    check("rst_ld_done", bus.ld_done, 0);
    check("rst_ld_done_fwd", bus.ld_done_fwd, 0);
    check("rst_ld_done_data", bus.ld_done_data, 0);
    tick();

    // SW@0x100 data 0xAA then LW@0x100: forwarded
    dispatch(1, 32'h1000); #1; check("t1_dis_idx0", bus.dis_idx, 0); tick();
    dispatch(0, 32'h1004); #1; check("t1_dis_idx1", bus.dis_idx, 1); tick();
    exe(0, 32'h100, 32'hAA); #1; check("t1_head_wait", bus.head_done, 0); tick();
    exe(1, 32'h100, 32'h0); #1; check("t1_head_done", bus.head_done, 1); tick();
    #1; check("t1_no_rd", bus.mem_rd_en, 0); check("t1_no_done_yet", bus.ld_done, 0); tick();
    #1;
    check("t1_ld_done", bus.ld_done, 1);
    check("t1_fwd", bus.ld_done_fwd, 1);
    check("t1_data", bus.ld_done_data, 32'hAA);
    check("t1_idx", bus.ld_done_idx, 1);
    check("t1_pc", bus.ld_done_pc, 32'h1004);
    tick();
    exe(0, 32'h104, 32'hBB); #1; check("t1_done_pulse", bus.ld_done, 0); tick();
    bus.ret_valid = 1; #1;
    check("t1_wr_en", bus.mem_wr_en, 1);
    check("t1_wr_addr", bus.mem_wr_addr, 32'h100);
    check("t1_wr_data", bus.mem_wr_data, 32'hAA);
    tick();
    bus.ret_valid = 1; #1;
    check("t1_ld_head_done", bus.head_done, 1);
    check("t1_ld_no_wr", bus.mem_wr_en, 0);
    tick();
    check("t1_rd_pulses", rd_pulses, 0);

    // LW@0x200 with no older store: memory read
    dispatch(0, 32'h2000); #1; check("t2_dis_idx", bus.dis_idx, 2); tick();
    exe(2, 32'h200, 32'h0); mem_val = 32'h55; #1; check("t2_rd_early", bus.mem_rd_en, 0); tick();
    #1; check("t2_rd_en", bus.mem_rd_en, 1); check("t2_rd_addr", bus.mem_rd_addr, 32'h200); tick();
    #1;
    check("t2_ld_done", bus.ld_done, 1);
    check("t2_data", bus.ld_done_data, 32'h55);
    check("t2_fwd", bus.ld_done_fwd, 0);
    check("t2_idx", bus.ld_done_idx, 2);
    check("t2_pc", bus.ld_done_pc, 32'h2000);
    check("t2_rd_once", bus.mem_rd_en, 0);
    tick();
    #1; check("t2_done_pulse", bus.ld_done, 0); check("t2_head_done", bus.head_done, 1);
    bus.ret_valid = 1; tick();
    check("t2_rd_pulses", rd_pulses, 1);

    // Unresolved older store blocks a resolved load
    dispatch(1, 32'h3000); #1; check("t3_dis_idx", bus.dis_idx, 3); tick();
    dispatch(0, 32'h3004); tick();
    exe(4, 32'h300, 32'h0); mem_val = 32'h33; tick();
    #1; check("t3_wait0", bus.mem_rd_en, 0);
    bus.ret_valid = 1; #1; check("t3_ret_ignored", bus.mem_wr_en, 0); tick();
    exe(3, 32'h380, 32'h77); #1; check("t3_wait1", bus.mem_rd_en, 0); tick();
    #1; check("t3_rd_en", bus.mem_rd_en, 1); check("t3_rd_addr", bus.mem_rd_addr, 32'h300); tick();
    #1;
    check("t3_ld_done", bus.ld_done, 1);
    check("t3_data", bus.ld_done_data, 32'h33);
    check("t3_fwd", bus.ld_done_fwd, 0);
    check("t3_idx", bus.ld_done_idx, 4);
    tick();
    bus.ret_valid = 1; #1;
    check("t3_wr_en", bus.mem_wr_en, 1);
    check("t3_wr_addr", bus.mem_wr_addr, 32'h380);
    check("t3_wr_data", bus.mem_wr_data, 32'h77);
    tick();
    bus.ret_valid = 1; tick();

    // Two stores to one word: youngest wins the forward; retire in order
    dispatch(1, 32'h5000); tick();
    dispatch(1, 32'h5004); tick();
    dispatch(0, 32'h5008); #1; check("t5_dis_idx", bus.dis_idx, 7); tick();
    exe(5, 32'h40, 32'h1); tick();
    exe(6, 32'h40, 32'h2); tick();
    exe(7, 32'h43, 32'h0); tick();
    #1; check("t5_no_rd", bus.mem_rd_en, 0); tick();
    #1;
    check("t5_ld_done", bus.ld_done, 1);
    check("t5_fwd", bus.ld_done_fwd, 1);
    check("t5_data", bus.ld_done_data, 32'h2);
    check("t5_idx", bus.ld_done_idx, 7);
    tick();
    bus.ret_valid = 1; #1;
    check("t5_wr1_addr", bus.mem_wr_addr, 32'h40);
    check("t5_wr1_data", bus.mem_wr_data, 32'h1);
    tick();
    bus.ret_valid = 1; #1; check("t5_wr2_data", bus.mem_wr_data, 32'h2); tick();
    bus.ret_valid = 1; #1; check("t5_ld_no_wr", bus.mem_wr_en, 0); tick();
    check("t5_rd_pulses", rd_pulses, 2);

    // Fill all entries with stores, drop the overflow dispatch, then stream
    for (int k = 0; k < DEPTH; k++) begin
      #1; check("t4_ready", bus.dis_ready, 1);
      dispatch(1, 32'h4000 + 32'(4 * k));
      if (k > 0) exe(slot(k - 1), 32'h1000 + 32'(4 * (k - 1)), 32'(k - 1));
      #1; check("t4_fill_idx", bus.dis_idx, slot(k));
      tick();
    end
    #1; check("t4_full", bus.dis_ready, 0);
    dispatch(1, 32'hDEAD);
    exe(slot(15), 32'h1000 + 32'(4 * 15), 32'd15);
    tick();
    #1; check("t4_full_still", bus.dis_ready, 0);
    bus.ret_valid = 1; #1;
    check("t4_ret0_data", bus.mem_wr_data, 0);
    check("t4_ret0_addr", bus.mem_wr_addr, 32'h1000);
    check("t4_ret_same_cycle", bus.dis_ready, 0);
    tick();
    #1; check("t4_ready_after_ret", bus.dis_ready, 1);
    for (int j = 0; j < 48; j++) begin
      bus.ret_valid = 1;
      dispatch(1, 32'h4000 + 32'(4 * (16 + j)));
      if (j > 0) exe(slot(15 + j), 32'h1000 + 32'(4 * (15 + j)), 32'(15 + j));
      #1;
      check("t4_stream_wr", bus.mem_wr_data, 32'(j + 1));
      check("t4_stream_idx", bus.dis_idx, slot(16 + j));
      tick();
    end
    bus.ret_valid = 1;
    exe(slot(63), 32'h1000 + 32'(4 * 63), 32'd63);
    #1; check("t4_drain_wr", bus.mem_wr_data, 32'd49); tick();
    for (int r = 50; r < 64; r++) begin
      bus.ret_valid = 1; #1;
      check("t4_drain_wr", bus.mem_wr_data, 32'(r));
      tick();
    end
    #1; check("t4_empty_head", bus.head_done, 0); check("t4_empty_ready", bus.dis_ready, 1);
    check("t4_empty_idx", bus.dis_idx, 8);

    // Flush in the same cycle as the read return
    dispatch(0, 32'h6000); tick();
    exe(8, 32'h600, 32'h0); mem_val = 32'h99; tick();
    #1; check("t6_rd_en", bus.mem_rd_en, 1); tick();
    bus.flush = 1; #1; check("t6_no_done_flush", bus.ld_done, 0); tick();
    #1;
    check("t6_no_done_after", bus.ld_done, 0);
    check("t6_ready", bus.dis_ready, 1);
    check("t6_dis_idx", bus.dis_idx, 0);
    check("t6_head_done", bus.head_done, 0);
    check("t6_rd_pulses", rd_pulses, 3);
    dispatch(1, 32'h7000); tick();
    exe(0, 32'h700, 32'h5A); tick();
    #1; check("t6_head_after_flush", bus.head_done, 1);

    // Reset mid-operation
    dispatch(0, 32'h8000); tick();
    rstn = 1'b0; tick();
    rstn = 1'b1; #1;
    check("rst2_dis_idx", bus.dis_idx, 0);
    check("rst2_head_done", bus.head_done, 0);
    check("rst2_ready", bus.dis_ready, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
